mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester round-robin controller that sequences and shares the 8x8 register-file memory (`en_w`/`en_r`/`address`/`data_in` port, registered `data_out`, `full_flag`/`empty_flag`). It accepts read and write commands from requesters A and B and serialises them into single-cycle memory enables. It returns read data with a valid pulse and, optionally, rejects writes to a full memory and reads from an empty one. It sits between the two client blocks and the memory instance.

## Interface
- `AW`, 3, address width; the memory depth is 2^AW.
- `DW`, 8, data width.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req_a`, `req_b` input 1: command request; held high until `gnt_x` is seen.
- `we_a`, `we_b` input 1: 1 = write, 0 = read; stable while `req_x` is high.
- `addr_a`, `addr_b` input AW: command address.
- `wdata_a`, `wdata_b` input DW: write data.
- `gnt_a`, `gnt_b` output 1: one-cycle pulse when that requester's command is issued or rejected.
- `err_a`, `err_b` output 1: one-cycle pulse coincident with `gnt_x` when the command is rejected.
- `rvalid_a`, `rvalid_b` output 1: one-cycle pulse when `rdata` holds that requester's read data.
- `rdata` output DW: read data shared by both requesters; holds its value until the next read completes.
- `busy` output 1: high whenever the state is not IDLE.
- `mem_en_w`, `mem_en_r` output 1: memory enables; at most one is high, for exactly one cycle per command.
- `mem_addr` output AW, `mem_wdata` output DW: memory command fields.
- `mem_rdata` input DW: registered memory read data.
- `mem_full`, `mem_empty` input 1: memory occupancy flags.

## Operation
- FSM states: IDLE, ISSUE, WAIT. Encoding is free.
- **IDLE**
  - If any `req_x` is high, pick a winner.
  - The winner's `we`, `addr` and `wdata` are latched into the command registers. `mem_addr` and `mem_wdata` are driven from these registers.
  - The state moves to ISSUE.
- **Arbitration**
  - A single request wins outright.
  - If both request, the winner is the requester not granted last.
  - `last_gnt` resets to B, so A wins the first tie.
  - `last_gnt` updates on every grant, including rejected ones.
- **ISSUE**
  - `gnt_x` is high for the winner.
  - For a write, `mem_en_w` is high; for a read, `mem_en_r` is high.
  - The state moves to WAIT unconditionally.
- **WAIT**
  - No memory enable is active.
  - For an accepted read, `mem_rdata` is captured into `rdata` at the end of this cycle, and `rvalid_x` is registered high for the following cycle.
  - The state moves to IDLE.
- WAIT also gives the memory's flags a cycle to settle after its counter updates. Flags sampled in IDLE are therefore current.
- A requester drops `req_x` on the edge after `gnt_x`. If `req_x` is still high in IDLE, it is treated as a new command.
- `rvalid_x` occurs in the IDLE cycle after WAIT. A new grant decision may be made in that same cycle.
- Requests arriving while `busy` is high wait. Nothing is queued beyond the held `req_x`.
- Reset, including mid-command:
  - The state returns to IDLE and any in-flight command is dropped, with no enable, `gnt` or `rvalid`.
  - `last_gnt` is set to B.
  - All outputs go to 0: `gnt_*`, `err_*`, `rvalid_*`, `rdata`, `busy`, `mem_en_w`, `mem_en_r`, `mem_addr`, `mem_wdata`.

## Timing
- Write: request in IDLE at cycle 0, `gnt` and `mem_en_w` at cycle 1, WAIT at cycle 2, IDLE at cycle 3. Throughput is one command per 3 cycles.
- Read: grant at cycle 1, `rdata` and `rvalid` at cycle 3. Latency from the request edge is 3 cycles.
- Back-to-back requests from both requesters alternate A, B, A, B with a 3-cycle period.
- `gnt_x`, `err_x`, `rvalid_x` and `mem_en_*` are registered outputs.

## Configuration
- Macro: `MEM_ARB_GUARD_EN`.
- **Defined:**
  - In IDLE, a winning write is rejected if `mem_full` is high, and a winning read is rejected if `mem_empty` is high.
  - A rejected command still goes through ISSUE and WAIT. In ISSUE, `gnt_x` and `err_x` are high and no memory enable is asserted.
  - A rejected read produces no `rvalid`, and `rdata` is unchanged.
- **Undefined:**
  - `err_a` and `err_b` are tied to 0.
  - `mem_full` and `mem_empty` are ignored.
  - Every granted command drives its memory enable.

## Test plan
- Reset, then A writes 0x5A to address 3 → `gnt_a` and `mem_en_w` in cycle 1 with `mem_addr`=3 and `mem_wdata`=0x5A; `busy` is 0 at cycle 3.
- A reads address 3 after that write → `mem_en_r` in cycle 1; `rvalid_a`=1 and `rdata`=0x5A in cycle 3; `rvalid_b` stays 0.
- `req_a` and `req_b` both held for 4 commands → grant order A, B, A, B, each 3 cycles apart, never two enables in one cycle.
- With `MEM_ARB_GUARD_EN` defined: 8 writes, then a ninth write from B → `gnt_b`=`err_b`=1 with no `mem_en_w`. After reset, a read → `err` asserted and no `rvalid`.
- Assert `rst` during WAIT of a read → no `rvalid`, all outputs 0, and the next tie is granted to A.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises read/write commands from two requesters onto one memory port.
// Define MEM_ARB_GUARD_EN to reject writes to a full memory and reads from an empty one.
module mem_arbiter #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req_a,
    input  logic          i_req_b,
    input  logic          i_we_a,
    input  logic          i_we_b,
    input  logic [AW-1:0] i_addr_a,
    input  logic [AW-1:0] i_addr_b,
    input  logic [DW-1:0] i_wdata_a,
    input  logic [DW-1:0] i_wdata_b,
    output logic          o_gnt_a,
    output logic          o_gnt_b,
    output logic          o_err_a,
    output logic          o_err_b,
    output logic          o_rvalid_a,
    output logic          o_rvalid_b,
    output logic [DW-1:0] o_rdata,
    output logic          o_busy,
    output logic          o_mem_en_w,
    output logic          o_mem_en_r,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_full,
    input  logic          i_mem_empty
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        r_state;
    logic          r_last_b;
    logic          r_cmd_b;
    logic          r_cmd_we;
    logic          r_cmd_rej;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_gnt_a;
    logic          r_gnt_b;
    logic          r_err_a;
    logic          r_err_b;
    logic          r_en_w;
    logic          r_en_r;
    logic          r_rvalid_a;
    logic          r_rvalid_b;

    logic          w_any_req;
    logic          w_pick_b;
    logic          w_we;
    logic          w_reject;

    // On a tie, B wins only if A was granted last.
    assign w_any_req = i_req_a | i_req_b;
    assign w_pick_b  = i_req_b & (~i_req_a | ~r_last_b);
    assign w_we      = w_pick_b ? i_we_b : i_we_a;

`ifdef MEM_ARB_GUARD_EN
    assign w_reject = w_we ? i_mem_full : i_mem_empty;
`else
    logic w_unused_flags;
    assign w_unused_flags = i_mem_full ^ i_mem_empty;
    assign w_reject       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last_b   <= 1'b1;
            r_cmd_b    <= 1'b0;
            r_cmd_we   <= 1'b0;
            r_cmd_rej  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_err_a    <= 1'b0;
            r_err_b    <= 1'b0;
            r_en_w     <= 1'b0;
            r_en_r     <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_last_b  <= w_pick_b;
                        r_cmd_b   <= w_pick_b;
                        r_cmd_we  <= w_we;
                        r_cmd_rej <= w_reject;
                        r_addr    <= w_pick_b ? i_addr_b : i_addr_a;
                        r_wdata   <= w_pick_b ? i_wdata_b : i_wdata_a;
                        r_gnt_a   <= ~w_pick_b;
                        r_gnt_b   <= w_pick_b;
                        r_err_a   <= ~w_pick_b & w_reject;
                        r_err_b   <= w_pick_b & w_reject;
                        r_en_w    <= w_we & ~w_reject;
                        r_en_r    <= ~w_we & ~w_reject;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_gnt_a <= 1'b0;
                    r_gnt_b <= 1'b0;
                    r_err_a <= 1'b0;
                    r_err_b <= 1'b0;
                    r_en_w  <= 1'b0;
                    r_en_r  <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // The memory registered its read data at the end of ISSUE.
                    if (!r_cmd_we && !r_cmd_rej) begin
                        r_rdata    <= i_mem_rdata;
                        r_rvalid_a <= ~r_cmd_b;
                        r_rvalid_b <= r_cmd_b;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_gnt_a     = r_gnt_a;
    assign o_gnt_b     = r_gnt_b;
    assign o_err_a     = r_err_a;
    assign o_err_b     = r_err_b;
    assign o_rvalid_a  = r_rvalid_a;
    assign o_rvalid_b  = r_rvalid_b;
    assign o_rdata     = r_rdata;
    assign o_busy      = (r_state != IDLE);
    assign o_mem_en_w  = r_en_w;
    assign o_mem_en_r  = r_en_r;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small 8x8 register-file memory model (write counter drives full/empty).
module tb_mem_arbiter;

`ifdef MEM_ARB_GUARD_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [2:0] addr_a = '0, addr_b = '0;
    logic [7:0] wdata_a = '0, wdata_b = '0;
    logic       gnt_a, gnt_b, err_a, err_b, rvalid_a, rvalid_b, busy, en_w, en_r;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [2:0] mem_addr;
    logic       mem_full, mem_empty;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(3), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .i_req_a(req_a), .i_req_b(req_b), .i_we_a(we_a), .i_we_b(we_b),
        .i_addr_a(addr_a), .i_addr_b(addr_b), .i_wdata_a(wdata_a), .i_wdata_b(wdata_b),
        .o_gnt_a(gnt_a), .o_gnt_b(gnt_b), .o_err_a(err_a), .o_err_b(err_b),
        .o_rvalid_a(rvalid_a), .o_rvalid_b(rvalid_b), .o_rdata(rdata), .o_busy(busy),
        .o_mem_en_w(en_w), .o_mem_en_r(en_r), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_full(mem_full), .i_mem_empty(mem_empty)
    );

    // Memory model: registered read port, occupancy counts writes up to the depth.
    logic [7:0] mem [8];
    logic [3:0] cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            mem_rdata <= '0;
        end else begin
            if (en_w) begin
                mem[mem_addr] <= mem_wdata;
                if (cnt != 4'd8) cnt <= cnt + 4'd1;
            end
            if (en_r) mem_rdata <= mem[mem_addr];
        end
    end
    assign mem_full  = (cnt == 4'd8);
    assign mem_empty = (cnt == 4'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {gnt_a, gnt_b, err_a, err_b, rvalid_a, rvalid_b, busy, en_w, en_r,
                  rdata, mem_addr, mem_wdata}, 32'h0);
    endtask

    // Raise one request in IDLE and return at the ISSUE cycle (cycle 1).
    task automatic run_cmd(input bit b, input bit we, input logic [2:0] ad, input logic [7:0] d);
        if (b) begin req_b = 1'b1; we_b = we; addr_b = ad; wdata_b = d; end
        else   begin req_a = 1'b1; we_a = we; addr_a = ad; wdata_a = d; end
        @(negedge clk);
    endtask

    // Drop requests after the grant and return at cycle 3 (IDLE again).
    task automatic finish_cmd();
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);

        // A writes 0x5A to address 3
        run_cmd(1'b0, 1'b1, 3'd3, 8'h5A);
        chk("wr_gnt", {gnt_a, gnt_b, err_a, en_w, en_r, busy}, 6'b100101);
        chk("wr_addr", mem_addr, 3'd3);
        chk("wr_data", mem_wdata, 8'h5A);
        req_a = 1'b0;
        @(negedge clk);
        chk("wr_wait", {gnt_a, en_w, en_r, busy}, 4'b0001);
        @(negedge clk);
        chk("wr_idle_busy", busy, 1'b0);

        // A reads address 3 back
        run_cmd(1'b0, 1'b0, 3'd3, 8'h00);
        chk("rd_issue", {gnt_a, gnt_b, en_w, en_r}, 4'b1001);
        finish_cmd();
        chk("rd_rvalid", {rvalid_a, rvalid_b, busy}, 3'b100);
        chk("rd_rdata", rdata, 8'h5A);
        @(negedge clk);
        chk("rd_rvalid_pulse", rvalid_a, 1'b0);
        chk("rd_rdata_hold", rdata, 8'h5A);

        // B writes 0xC3 to address 5, making B the last grant
        run_cmd(1'b1, 1'b1, 3'd5, 8'hC3);
        chk("wrb_gnt", {gnt_a, gnt_b, en_w, en_r}, 4'b0110);
        finish_cmd();

        // Both requesters held for four writes: A, B, A, B
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd1; wdata_a = 8'h11;
        req_b = 1'b1; we_b = 1'b1; addr_b = 3'd2; wdata_b = 8'h22;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("tie_gnt%0d", k), {gnt_a, gnt_b, en_w, en_r}, {k[0] == 1'b0, k[0] == 1'b1, 2'b10});
            @(negedge clk);
            chk($sformatf("tie_wait%0d", k), {gnt_a, gnt_b, en_w, en_r}, 4'b0000);
            @(negedge clk);
            if (k == 3) begin req_a = 1'b0; req_b = 1'b0; end
            chk($sformatf("tie_idle%0d", k), busy, 1'b0);
        end

        // B reads address 2 (written during the tie run)
        run_cmd(1'b1, 1'b0, 3'd2, 8'h00);
        chk("rdb_issue", {gnt_a, gnt_b, en_w, en_r}, 4'b0101);
        finish_cmd();
        chk("rdb_rvalid", {rvalid_a, rvalid_b}, 2'b01);
        chk("rdb_rdata", rdata, 8'h22);

        // A reads address 1, reset asserted during WAIT
        run_cmd(1'b0, 1'b0, 3'd1, 8'h00);
        chk("rst_rd_issue", {gnt_a, en_r}, 2'b11);
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_wait");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_rvalid", {rvalid_a, rvalid_b, busy}, 3'b000);

        // First tie after reset goes to A even though A was granted last
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd4; wdata_a = 8'h44;
        req_b = 1'b1; we_b = 1'b1; addr_b = 3'd6; wdata_b = 8'h66;
        @(negedge clk);
        chk("rst_tie_gnt", {gnt_a, gnt_b}, 2'b10);
        finish_cmd();

        // Occupancy guard: read from empty memory, then a write beyond full
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_cmd(1'b0, 1'b0, 3'd0, 8'h00);
        chk("empty_rd", {gnt_a, err_a, en_w, en_r}, {1'b1, G, 1'b0, !G});
        finish_cmd();
        chk("empty_rvalid", rvalid_a, !G);
        for (int i = 0; i < 8; i++) begin
            run_cmd(1'b0, 1'b1, i[2:0], 8'hA0 + 8'(i));
            chk($sformatf("fill_wr%0d", i), {gnt_a, err_a, en_w}, 3'b101);
            finish_cmd();
        end
        run_cmd(1'b1, 1'b1, 3'd7, 8'hEE);
        chk("full_wr", {gnt_b, err_b, en_w, en_r}, {1'b1, G, !G, 1'b0});
        finish_cmd();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
